// File: rtl/exec_unit.sv
// Single-issue integer execute unit with a register file, one-cycle ALU ops and a shift-add multiplier.
// Latency: ALU result reported the cycle after accept; MUL/MULHU reported XLEN+1 cycles after accept.
// Backpressure: Issue_ready drops for the whole multiply; Ext writes are always accepted.
module exec_unit #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int IMM_W    = 12,
    parameter int IMM_SEXT = 0
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Issue_valid,
    output logic                     Issue_ready,
    input  logic [3:0]               Op,
    input  logic [$clog2(NREGS)-1:0] Rs1_id,
    input  logic [$clog2(NREGS)-1:0] Rs2_id,
    input  logic [$clog2(NREGS)-1:0] Rd_id,
    input  logic [IMM_W-1:0]         Imm,
    input  logic                     Imm_enable,
    input  logic                     Ext_we,
    input  logic [$clog2(NREGS)-1:0] Ext_id,
    input  logic [XLEN-1:0]          Ext_data,
    output logic                     Wb_valid,
    output logic [$clog2(NREGS)-1:0] Wb_id,
    output logic [XLEN-1:0]          Wb_data,
    output logic                     Busy,
    input  logic [$clog2(NREGS)-1:0] Dbg_id,
    output logic [XLEN-1:0]          Dbg_data
);
    localparam int RW = $clog2(NREGS);
    localparam int SW = $clog2(XLEN);
    localparam logic [SW-1:0] CNT_LAST = SW'(XLEN - 1);

    typedef enum logic {IDLE, MUL} state_t;
    state_t state, state_nxt;

    logic [XLEN-1:0]   regs [NREGS];
    logic [XLEN-1:0]   op1, op2, imm_ext, alu_res;
    logic [SW-1:0]     shamt;
    logic              accept, is_mul, mul_done;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] prod, prod_nxt;
    logic [XLEN:0]     mul_sum;
    logic [SW-1:0]     cnt;
    logic              mul_hi;
    logic [RW-1:0]     mul_rd;
    logic              int_we;
    logic [RW-1:0]     int_id;
    logic [XLEN-1:0]   int_data;

    assign imm_ext = (IMM_SEXT != 0) ? {{(XLEN-IMM_W){Imm[IMM_W-1]}}, Imm}
                                     : {{(XLEN-IMM_W){1'b0}}, Imm};
    assign op1      = regs[Rs1_id];
    assign op2      = Imm_enable ? imm_ext : regs[Rs2_id];
    assign shamt    = op2[SW-1:0];
    assign is_mul   = (Op == 4'd10) || (Op == 4'd11);
    assign accept   = Issue_valid && Issue_ready;
    assign mul_done = Busy && (cnt == CNT_LAST);
    assign Dbg_data = regs[Dbg_id];

    always_comb begin
        alu_res = '0;
        case (Op)
            4'd0:    alu_res = op1 + op2;
            4'd1:    alu_res = op1 - op2;
            4'd2:    alu_res = op1 & op2;
            4'd3:    alu_res = op1 | op2;
            4'd4:    alu_res = op1 ^ op2;
            4'd5:    alu_res = op1 << shamt;
            4'd6:    alu_res = op1 >> shamt;
            4'd7:    alu_res = XLEN'($signed(op1) >>> shamt);
            4'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            4'd9:    alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        Issue_ready = 1'b0;
        Busy        = 1'b0;
        case (state)
            IDLE: begin
                Issue_ready = 1'b1;
                if (Issue_valid && is_mul) state_nxt = MUL;
            end
            MUL: begin
                Busy = 1'b1;
                if (cnt == CNT_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Multiplier bits are consumed from prod[0]; partial sum enters at the top.
    assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? mcand : {XLEN{1'b0}})};
    assign prod_nxt = {mul_sum, prod[XLEN-1:1]};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mcand  <= '0;
            prod   <= '0;
            cnt    <= '0;
            mul_hi <= 1'b0;
            mul_rd <= '0;
        end else if (accept && is_mul) begin
            mcand  <= op1;
            prod   <= {{XLEN{1'b0}}, op2};
            cnt    <= '0;
            mul_hi <= (Op == 4'd11);
            mul_rd <= Rd_id;
        end else if (Busy) begin
            prod <= prod_nxt;
            cnt  <= cnt + 1'b1;
        end
    end

    assign int_we   = (accept && !is_mul) || mul_done;
    assign int_id   = mul_done ? mul_rd : Rd_id;
    assign int_data = mul_done ? (mul_hi ? prod_nxt[2*XLEN-1:XLEN] : prod_nxt[XLEN-1:0]) : alu_res;

    // Internal result wins over a same-edge external write to the same register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (int_we && int_id == RW'(i))      regs[i] <= int_data;
                else if (Ext_we && Ext_id == RW'(i)) regs[i] <= Ext_data;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Wb_valid <= 1'b0;
            Wb_id    <= '0;
            Wb_data  <= '0;
        end else begin
            Wb_valid <= int_we;
            if (int_we) begin
                Wb_id   <= int_id;
                Wb_data <= int_data;
            end
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: zero-extend and sign-extend instances share stimulus; a transaction-level
// model is compared every cycle and directed vectors pin literal results.
module tb_exec_unit;
    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    logic            Issue_valid, Imm_enable, Ext_we;
    logic [3:0]      Op;
    logic [RW-1:0]   Rs1_id, Rs2_id, Rd_id, Ext_id, Dbg_id;
    logic [11:0]     Imm;
    logic [XLEN-1:0] Ext_data;
    logic [1:0]      rdy, busy, wbv;
    logic [RW-1:0]   wbid [2];
    logic [XLEN-1:0] wbd [2];
    logic [XLEN-1:0] dbg [2];

    exec_unit #(.XLEN(XLEN), .NREGS(32), .IMM_W(12), .IMM_SEXT(0)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .Issue_valid(Issue_valid), .Issue_ready(rdy[0]), .Op(Op),
        .Rs1_id(Rs1_id), .Rs2_id(Rs2_id), .Rd_id(Rd_id), .Imm(Imm), .Imm_enable(Imm_enable),
        .Ext_we(Ext_we), .Ext_id(Ext_id), .Ext_data(Ext_data), .Wb_valid(wbv[0]), .Wb_id(wbid[0]),
        .Wb_data(wbd[0]), .Busy(busy[0]), .Dbg_id(Dbg_id), .Dbg_data(dbg[0]));

    exec_unit #(.XLEN(XLEN), .NREGS(32), .IMM_W(12), .IMM_SEXT(1)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .Issue_valid(Issue_valid), .Issue_ready(rdy[1]), .Op(Op),
        .Rs1_id(Rs1_id), .Rs2_id(Rs2_id), .Rd_id(Rd_id), .Imm(Imm), .Imm_enable(Imm_enable),
        .Ext_we(Ext_we), .Ext_id(Ext_id), .Ext_data(Ext_data), .Wb_valid(wbv[1]), .Wb_id(wbid[1]),
        .Wb_data(wbd[1]), .Busy(busy[1]), .Dbg_id(Dbg_id), .Dbg_data(dbg[1]));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [XLEN-1:0] mr [2][32];
    int              mleft;
    logic [RW-1:0]   m_rd, m_wbid, iid;
    logic [XLEN-1:0] m_res [2];
    logic [XLEN-1:0] m_wbd [2];
    logic [XLEN-1:0] idat [2];
    logic            m_wbv, iw;
    logic [XLEN-1:0] ma, mb;
    logic [63:0]     mprod;

    function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op, input logic [XLEN-1:0] a, b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return 32'($signed(a) >>> b[4:0]);
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] ref_imm(input logic [11:0] im, input int k);
        return (k == 1) ? {{20{im[11]}}, im} : {20'd0, im};
    endfunction

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 32; i++) mr[k][i] = '0;
                m_wbd[k] = '0;
            end
            mleft = 0; m_wbv = 1'b0; m_wbid = '0;
        end else begin
            iw = 1'b0;
            iid = '0;
            if (mleft > 0) begin
                mleft--;
                if (mleft == 0) begin
                    iw = 1'b1; iid = m_rd;
                    idat[0] = m_res[0]; idat[1] = m_res[1];
                end
            end else if (Issue_valid) begin
                for (int k = 0; k < 2; k++) begin
                    ma = mr[k][Rs1_id];
                    mb = Imm_enable ? ref_imm(Imm, k) : mr[k][Rs2_id];
                    mprod = 64'(ma) * 64'(mb);
                    m_res[k] = (Op == 4'd10) ? mprod[31:0] : mprod[63:32];
                    idat[k] = ref_alu(Op, ma, mb);
                end
                if (Op == 4'd10 || Op == 4'd11) begin
                    mleft = XLEN; m_rd = Rd_id;
                end else begin
                    iw = 1'b1; iid = Rd_id;
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (Ext_we && Ext_id != 0) mr[k][Ext_id] = Ext_data;
                if (iw && iid != 0)        mr[k][iid] = idat[k];
            end
            m_wbv = iw;
            if (iw) begin
                m_wbid = iid; m_wbd[0] = idat[0]; m_wbd[1] = idat[1];
            end
        end
    end

    always @(negedge Clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("m_ready%0d", k), 64'(rdy[k]), 64'(mleft == 0));
            chk($sformatf("m_busy%0d", k), 64'(busy[k]), 64'(mleft > 0));
            chk($sformatf("m_wbv%0d", k), 64'(wbv[k]), 64'(m_wbv));
            chk($sformatf("m_wbid%0d", k), 64'(wbid[k]), 64'(m_wbid));
            chk($sformatf("m_wbd%0d", k), 64'(wbd[k]), 64'(m_wbd[k]));
            chk($sformatf("m_dbg%0d_r%0d", k, Dbg_id), 64'(dbg[k]), 64'(mr[k][Dbg_id]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic ext(input int id, input logic [XLEN-1:0] d);
        Ext_we = 1'b1; Ext_id = RW'(id); Ext_data = d;
        step();
        Ext_we = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input int rs1, input int rs2, input int rd,
                         input logic [11:0] im, input logic ie);
        Issue_valid = 1'b1; Op = op; Rs1_id = RW'(rs1); Rs2_id = RW'(rs2); Rd_id = RW'(rd);
        Imm = im; Imm_enable = ie;
        step();
        Issue_valid = 1'b0; Imm_enable = 1'b0; Ext_we = 1'b0;
    endtask

    task automatic dbg_lit(input string nm, input int id, input logic [XLEN-1:0] exp);
        Dbg_id = RW'(id);
        #1;
        chk(nm, 64'(dbg[0]), 64'(exp));
    endtask

    // Counts cycles from the first cycle after accept until Wb_valid, bounded.
    task automatic wait_wb(output int cyc, output int nbusy, output int nrdy);
        cyc = 1; nbusy = 0; nrdy = 0;
        while (!wbv[0] && cyc <= 40) begin
            if (busy[0]) nbusy++;
            if (rdy[0])  nrdy++;
            cyc++;
            step();
        end
    endtask

    logic [3:0]      tab_op  [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd13};
    logic [XLEN-1:0] tab_exp [7] = '{32'h12345669, 32'h00000008, 32'h1234567F, 32'h12345677,
                                     32'h2B3C0000, 32'h00002468, 32'h00000000};
    int cyc, nbusy, nrdy;

    initial begin
        Rst_n = 1'b0; Issue_valid = 1'b0; Op = '0; Rs1_id = '0; Rs2_id = '0; Rd_id = '0;
        Imm = '0; Imm_enable = 1'b0; Ext_we = 1'b0; Ext_id = '0; Ext_data = '0; Dbg_id = '0;
        repeat (3) step();
        chk("rst_wbv", 64'(wbv[0]), 64'd0);
        chk("rst_busy", 64'(busy[0]), 64'd0);
        chk("rst_ready", 64'(rdy[0]), 64'd1);
        Rst_n = 1'b1;
        step();

        ext(1, 32'd5); ext(2, 32'd7);
        issue(4'd0, 1, 2, 3, 12'd0, 1'b0);
        chk("add_wbv", 64'(wbv[0]), 64'd1);
        chk("add_wbid", 64'(wbid[0]), 64'd3);
        chk("add_wbd", 64'(wbd[0]), 64'd12);
        dbg_lit("add_dbg_r3", 3, 32'd12);
        step();
        chk("add_wbv_pulse", 64'(wbv[0]), 64'd0);
        chk("add_wbd_hold", 64'(wbd[0]), 64'd12);

        ext(1, 32'hFFFFFFFF);
        issue(4'd0, 1, 0, 5, 12'h001, 1'b1);
        chk("addi_zext", 64'(wbd[0]), 64'd0);
        issue(4'd0, 1, 0, 6, 12'hFFF, 1'b1);
        chk("addi_sext", 64'(wbd[1]), 64'hFFFFFFFE);
        chk("addi_zext_fff", 64'(wbd[0]), 64'h00000FFE);

        ext(2, 32'd2);
        Issue_valid = 1'b1; Op = 4'd10; Rs1_id = 5'd1; Rs2_id = 5'd2; Rd_id = 5'd7;
        step();
        Op = 4'd0; Rs1_id = 5'd2; Rd_id = 5'd8;   // held offer during the multiply
        wait_wb(cyc, nbusy, nrdy);
        chk("mul_lat", 64'(cyc), 64'd33);
        chk("mul_busy_cycles", 64'(nbusy), 64'd32);
        chk("mul_ready_low", 64'(nrdy), 64'd0);
        chk("mul_wbid", 64'(wbid[0]), 64'd7);
        chk("mul_wbd", 64'(wbd[0]), 64'hFFFFFFFE);
        Issue_valid = 1'b0;
        step();
        dbg_lit("mul_held_ignored_r8", 8, 32'd0);
        issue(4'd11, 1, 2, 9, 12'd0, 1'b0);
        wait_wb(cyc, nbusy, nrdy);
        chk("mulhu_lat", 64'(cyc), 64'd33);
        chk("mulhu_wbd", 64'(wbd[0]), 64'd1);
        step();

        ext(1, 32'h80000000); ext(2, 32'd33);
        issue(4'd7, 1, 2, 10, 12'd0, 1'b0);
        chk("sra", 64'(wbd[0]), 64'hC0000000);
        ext(1, 32'hFFFFFFFF); ext(2, 32'd1);
        issue(4'd8, 1, 2, 11, 12'd0, 1'b0);
        chk("slt", 64'(wbd[0]), 64'd1);
        issue(4'd9, 1, 2, 12, 12'd0, 1'b0);
        chk("sltu", 64'(wbd[0]), 64'd0);

        issue(4'd0, 2, 2, 0, 12'd0, 1'b0);
        chk("r0_wbv", 64'(wbv[0]), 64'd1);
        chk("r0_wbd", 64'(wbd[0]), 64'd2);
        dbg_lit("r0_stays", 0, 32'd0);
        ext(1, 32'd1); ext(2, 32'd2);
        Ext_we = 1'b1; Ext_id = 5'd4; Ext_data = 32'd9;
        issue(4'd0, 1, 2, 4, 12'd0, 1'b0);
        dbg_lit("same_id_internal_wins", 4, 32'd3);
        Ext_we = 1'b1; Ext_id = 5'd1; Ext_data = 32'd100;
        issue(4'd0, 1, 2, 14, 12'd0, 1'b0);
        chk("no_bypass", 64'(wbd[0]), 64'd3);
        dbg_lit("ext_other_id", 1, 32'd100);

        ext(1, 32'h12345678); ext(2, 32'h0000000F);
        for (int i = 0; i < 7; i++) begin
            issue(tab_op[i], 1, 2, 15 + i, 12'd0, 1'b0);
            chk($sformatf("tab_op%0d", tab_op[i]), 64'(wbd[0]), 64'(tab_exp[i]));
        end

        issue(4'd10, 1, 2, 25, 12'd0, 1'b0);
        repeat (9) step();
        chk("pre_abort_busy", 64'(busy[0]), 64'd1);
        Rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy[0]), 64'd0);
        chk("abort_wbv", 64'(wbv[0]), 64'd0);
        for (int i = 0; i < 32; i++) dbg_lit($sformatf("abort_r%0d", i), i, 32'd0);
        step();
        Rst_n = 1'b1;
        repeat (40) begin
            step();
            if (wbv[0]) chk("abort_no_wb", 64'(wbv[0]), 64'd0);
        end
        chk("abort_ready", 64'(rdy[0]), 64'd1);
        dbg_lit("abort_r25", 25, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
